br_resolve_unit: RTL

- Parametrised, pipelined branch resolution unit for the execute stage; successor to the combinational branch-condition evaluator.
- Evaluates the branch condition and checks it against the front-end prediction (direction and target).
- Produces the redirect PC and a mispredict flag through a valid/ready elastic pipeline of configurable depth.
- Supports flush and keeps saturating branch and mispredict performance counters.

---
 rtl/br_resolve_unit_if.sv | 33 +++
 rtl/br_resolve_unit.sv | 129 ++++++++++++
 2 files changed

// File: rtl/br_resolve_unit_if.sv
// Request/result bundle for br_resolve_unit. The master side issues branches and consumes results.
// The slave side is the resolve unit.
interface br_resolve_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       br_sel;
    logic [XLEN-1:0]  op_a;
    logic [XLEN-1:0]  op_b;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  target;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_target;
    logic             out_valid;
    logic             out_ready;
    logic             taken;
    logic             mispredict;
    logic [XLEN-1:0]  redirect_pc;
    logic [CNT_W-1:0] cnt_branch;
    logic [CNT_W-1:0] cnt_mispred;

    modport master (
        output in_valid, br_sel, op_a, op_b, pc, target, pred_taken, pred_target, out_ready,
        input  in_ready, out_valid, taken, mispredict, redirect_pc, cnt_branch, cnt_mispred
    );

    modport slave (
        input  in_valid, br_sel, op_a, op_b, pc, target, pred_taken, pred_target, out_ready,
        output in_ready, out_valid, taken, mispredict, redirect_pc, cnt_branch, cnt_mispred
    );
endinterface

// File: rtl/br_resolve_unit.sv
// Branch resolution: evaluates the condition, checks the prediction, emits redirect PC and mispredict.
// Latency STAGES cycles with no stall; one op per cycle.
// Backpressure: ops collapse toward the output while out_ready=0; in_ready drops once all stages are full.
module br_resolve_unit #(
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    br_resolve_unit_if.slave bus
);

    generate
        if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
            $error("br_resolve_unit: STAGES must be in 1..3");
        end
    endgenerate

    typedef struct packed {
        logic [2:0]      br_sel;
        logic            taken;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
        logic            pred_taken;
        logic [XLEN-1:0] pred_target;
    } stage_t;

    stage_t            in_dat;
    logic              cond_taken;
    stage_t            st_dat [STAGES];
    logic [STAGES-1:0] st_vld;
    logic [STAGES-1:0] st_rdy;
    stage_t            last_dat;
    logic              last_vld;
    logic              last_mis;
    logic              out_hs;
    logic [CNT_W-1:0]  cnt_br;
    logic [CNT_W-1:0]  cnt_mis;

    always_comb begin
        cond_taken = 1'b0;
        case (bus.br_sel)
            3'b001:  cond_taken = (bus.op_a == bus.op_b);
            3'b010:  cond_taken = (bus.op_a != bus.op_b);
            3'b011:  cond_taken = ($signed(bus.op_a) <  $signed(bus.op_b));
            3'b100:  cond_taken = ($signed(bus.op_a) >= $signed(bus.op_b));
            3'b101:  cond_taken = (bus.op_a <  bus.op_b);
            3'b110:  cond_taken = (bus.op_a >= bus.op_b);
            3'b111:  cond_taken = 1'b1;
            default: cond_taken = 1'b0;
        endcase
    end

    always_comb begin
        in_dat             = '0;
        in_dat.br_sel      = bus.br_sel;
        in_dat.taken       = cond_taken;
        in_dat.pc          = bus.pc;
        in_dat.target      = bus.target;
        in_dat.pred_taken  = bus.pred_taken;
        in_dat.pred_target = bus.pred_target;
    end

    // A stage can load iff some stage at or below it is empty, or the output drains this cycle.
    // Written without a stage-to-stage chain so each ready depends only on state and out_ready.
    always_comb begin
        st_rdy = '0;
        for (int i = 0; i < STAGES; i++) begin
            st_rdy[i] = bus.out_ready || (|(~st_vld >> i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_vld  <= '0;
            cnt_br  <= '0;
            cnt_mis <= '0;
            for (int i = 0; i < STAGES; i++) begin
                st_dat[i] <= '0;
            end
        end else begin
            // A result consumed in a flush cycle still retires.
            if (out_hs && (last_dat.br_sel != 3'b000) && (cnt_br != {CNT_W{1'b1}})) begin
                cnt_br <= cnt_br + CNT_W'(1);
            end
            if (out_hs && last_mis && (cnt_mis != {CNT_W{1'b1}})) begin
                cnt_mis <= cnt_mis + CNT_W'(1);
            end

            if (st_rdy[0]) begin
                st_vld[0] <= bus.in_valid;
                if (bus.in_valid) begin
                    st_dat[0] <= in_dat;
                end
            end
            for (int i = 1; i < STAGES; i++) begin
                if (st_rdy[i]) begin
                    st_vld[i] <= st_vld[i-1];
                    if (st_vld[i-1]) begin
                        st_dat[i] <= st_dat[i-1];
                    end
                end
            end

            if (flush) begin
                st_vld <= '0;
            end
        end
    end

    assign last_dat = st_dat[STAGES-1];
    assign last_vld = st_vld[STAGES-1];
    assign out_hs   = last_vld && bus.out_ready;
    assign last_mis = (last_dat.taken != last_dat.pred_taken) ||
                      (last_dat.taken && (last_dat.pred_target != last_dat.target));

    // Result fields read as zero whenever no result is presented.
    assign bus.in_ready    = st_rdy[0];
    assign bus.out_valid   = last_vld;
    assign bus.taken       = last_vld && last_dat.taken;
    assign bus.mispredict  = last_vld && last_mis;
    assign bus.redirect_pc = !last_vld      ? '0 :
                             last_dat.taken ? last_dat.target : (last_dat.pc + XLEN'(4));
    assign bus.cnt_branch  = cnt_br;
    assign bus.cnt_mispred = cnt_mis;

endmodule
